dm_cache: RTL and testbench

- Direct-mapped, one-word-per-line data cache with an integrated backing main memory.
- Serves one read port and one write port on a single clock.
- Writes are write-through and write-allocate.
- Used as the data-memory stage model; it reports hit/miss on every read so upstream logic and benches can track locality.

---
 rtl/dm_cache.sv | 88 ++++++++
 tb/tb_dm_cache.sv | 120 ++++++++++++
 2 files changed

// File: rtl/dm_cache.sv
// Direct-mapped, one-word-per-line write-through/write-allocate data cache
// with an integrated backing memory; every request completes in one cycle.
module dm_cache #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int INDEX_W = 4,
  parameter int MEM_AW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read1,
  input  logic              r1e,
  input  logic [ADDR_W-1:0] write1,
  input  logic [DATA_W-1:0] writedata,
  input  logic              w1e,
  output logic [DATA_W-1:0] readout1,
  output logic              readHit
);

  localparam int LINES     = 1 << INDEX_W;
  localparam int TAG_W     = ADDR_W - INDEX_W;
  localparam int MEM_DEPTH = 1 << MEM_AW;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [DATA_W-1:0] lines [LINES];
  logic [DATA_W-1:0] mem   [MEM_DEPTH];

  // A word never written reads back as its own address, giving the
  // mem[i] = i power-up image without a reset on the memory array.
  logic [MEM_DEPTH-1:0] mem_wr = '0;

  logic [INDEX_W-1:0] r_idx, w_idx;
  logic [TAG_W-1:0]   r_tag, w_tag;
  logic [MEM_AW-1:0]  r_ma, w_ma;
  logic               hit;
  logic [DATA_W-1:0]  mem_q;

  assign r_idx = read1[INDEX_W-1:0];
  assign r_tag = read1[ADDR_W-1:INDEX_W];
  assign r_ma  = read1[MEM_AW-1:0];
  assign w_idx = write1[INDEX_W-1:0];
  assign w_tag = write1[ADDR_W-1:INDEX_W];
  assign w_ma  = write1[MEM_AW-1:0];

  assign hit   = valid[r_idx] && (tags[r_idx] == r_tag);
  assign mem_q = mem_wr[r_ma] ? mem[r_ma] : DATA_W'(r_ma);

  // Write has priority over a simultaneous read; the read is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      readout1 <= '0;
      readHit  <= 1'b0;
    end else begin
      readHit <= 1'b0;
      if (w1e) begin
        valid[w_idx] <= 1'b1;
      end else if (r1e) begin
        readHit <= hit;
        if (hit) begin
          readout1 <= lines[r_idx];
        end else begin
          readout1     <= mem_q;
          valid[r_idx] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w1e) begin
      tags[w_idx]  <= w_tag;
      lines[w_idx] <= writedata;
    end else if (r1e && !hit) begin
      tags[r_idx]  <= r_tag;
      lines[r_idx] <= mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (w1e) begin
      mem[w_ma]    <= writedata;
      mem_wr[w_ma] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dm_cache.sv
// Directed bench for dm_cache: hit/miss sequencing, write-through, aliasing,
// write priority and asynchronous reset with memory retention.
module tb_dm_cache;

  logic        clk;
  logic        rst_n;
  logic [15:0] read1;
  logic        r1e;
  logic [15:0] write1;
  logic [15:0] writedata;
  logic        w1e;
  logic [15:0] readout1;
  logic        readHit;

  int checks = 0;
  int errors = 0;

  dm_cache dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read1     (read1),
    .r1e       (r1e),
    .write1    (write1),
    .writedata (writedata),
    .w1e       (w1e),
    .readout1  (readout1),
    .readHit   (readHit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one request for one edge, then sample 1 time unit after the edge.
  task automatic op(input logic r, input logic [15:0] ra, input logic w,
                    input logic [15:0] wa, input logic [15:0] wd);
    r1e       = r;
    read1     = ra;
    w1e       = w;
    write1    = wa;
    writedata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [15:0] ra,
                    input logic exp_hit, input logic [15:0] exp_data);
    op(1'b1, ra, 1'b0, 16'd0, 16'd0);
    check({tag, "_hit"}, {15'd0, readHit}, {15'd0, exp_hit});
    check({tag, "_data"}, readout1, exp_data);
  endtask

  initial begin
    rst_n = 1'b0;
    r1e = 1'b0; w1e = 1'b0;
    read1 = '0; write1 = '0; writedata = '0;
    #3;
    check("rst_hit", {15'd0, readHit}, 16'd0);
    check("rst_data", readout1, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    rd("r0_miss", 16'd0, 1'b0, 16'd0);
    rd("r0_hit", 16'd0, 1'b1, 16'd0);
    rd("r1_miss", 16'd1, 1'b0, 16'd1);
    rd("r1_hit", 16'd1, 1'b1, 16'd1);

    op(1'b0, 16'd0, 1'b1, 16'd1, 16'd343);
    check("w1_hit", {15'd0, readHit}, 16'd0);
    check("w1_hold", readout1, 16'd1);
    rd("r1_after_w", 16'd1, 1'b1, 16'd343);

    rd("r16_miss", 16'd16, 1'b0, 16'd16);
    rd("r16_hit", 16'd16, 1'b1, 16'd16);
    rd("r128_miss", 16'd128, 1'b0, 16'd128);
    rd("r16_evicted", 16'd16, 1'b0, 16'd16);
    rd("r1_still", 16'd1, 1'b1, 16'd343);

    op(1'b1, 16'd5, 1'b1, 16'd2, 16'd77);
    check("rw_hit", {15'd0, readHit}, 16'd0);
    check("rw_hold", readout1, 16'd343);
    rd("r2_hit", 16'd2, 1'b1, 16'd77);

    op(1'b0, 16'd0, 1'b0, 16'd0, 16'd0);
    check("idle_hit", {15'd0, readHit}, 16'd0);
    check("idle_hold", readout1, 16'd77);

    // 0x0102 aliases mem[2] and line 2 with a different tag.
    rd("alias_miss", 16'h0102, 1'b0, 16'd77);
    rd("r2_evicted", 16'd2, 1'b0, 16'd77);
    rd("r3_miss", 16'd3, 1'b0, 16'd3);
    check("r3_line_data", readout1, 16'd3);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_hit", {15'd0, readHit}, 16'd0);
    check("async_rst_data", readout1, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    rd("post_r1_miss", 16'd1, 1'b0, 16'd343);
    rd("post_r1_hit", 16'd1, 1'b1, 16'd343);
    rd("post_r2_miss", 16'd2, 1'b0, 16'd77);
    rd("post_r200_miss", 16'd200, 1'b0, 16'd200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
